// File: rtl/static_vga_controller_if.sv
// Raster output bundle of the static VGA controller: visible pixel
// coordinate and active-low sync pulses. The timing generator drives it
// through the master modport. A pixel source reads it through the slave
// modport.
// The optional visible flag exists only when STATIC_VGA_VISIBLE_EN is defined.
interface static_vga_controller_if #(
  parameter int LineAddressWidth   = 9,
  parameter int ColumnAddressWidth = 10
);
  logic [LineAddressWidth-1:0]   line;
  logic [ColumnAddressWidth-1:0] column;
  logic                          verticalSync;
  logic                          horizontalSync;
`ifdef STATIC_VGA_VISIBLE_EN
  logic                          visible;

  modport master (output line, column, verticalSync, horizontalSync, visible);
  modport slave  (input  line, column, verticalSync, horizontalSync, visible);
`else
  modport master (output line, column, verticalSync, horizontalSync);
  modport slave  (input  line, column, verticalSync, horizontalSync);
`endif
endinterface

// File: rtl/static_vga_controller.sv
// Free-running VGA raster timing generator. The default timing is 640x480@60.
// A horizontal counter runs over every clock of a line. A vertical counter
// steps once per line. All outputs are registered from the next counter
// values, so they line up with the counters with no skew.
// Optional feature macro: STATIC_VGA_VISIBLE_EN adds the registered
// active-area flag "visible".
module static_vga_controller #(
  parameter int Width              = 640,
  parameter int Height             = 480,
  parameter int LineAddressWidth   = 9,
  parameter int ColumnAddressWidth = 10,
  parameter int HFrontPorch        = 16,
  parameter int HSyncPulse         = 96,
  parameter int HBackPorch         = 48,
  parameter int VFrontPorch        = 10,
  parameter int VSyncPulse         = 2,
  parameter int VBackPorch         = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  static_vga_controller_if.master vga
);

  localparam int HTotal = Width + HFrontPorch + HSyncPulse + HBackPorch;
  localparam int VTotal = Height + VFrontPorch + VSyncPulse + VBackPorch;
  localparam int HW     = $clog2(HTotal);
  localparam int VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast      = HW'(HTotal - 1);
  localparam logic [HW-1:0] HVisEnd    = HW'(Width);
  localparam logic [HW-1:0] HSyncStart = HW'(Width + HFrontPorch);
  localparam logic [HW-1:0] HSyncEnd   = HW'(Width + HFrontPorch + HSyncPulse);
  localparam logic [VW-1:0] VLast      = VW'(VTotal - 1);
  localparam logic [VW-1:0] VVisEnd    = VW'(Height);
  localparam logic [VW-1:0] VSyncStart = VW'(Height + VFrontPorch);
  localparam logic [VW-1:0] VSyncEnd   = VW'(Height + VFrontPorch + VSyncPulse);

  logic [HW-1:0]                 hcnt_q, hcnt_d;
  logic [VW-1:0]                 vcnt_q, vcnt_d;
  logic [LineAddressWidth-1:0]   line_q, line_d;
  logic [ColumnAddressWidth-1:0] column_q, column_d;
  logic                          hsync_q, hsync_d;
  logic                          vsync_q, vsync_d;
  logic                          active_d;

  // Next raster position, and the outputs that belong to that position.
  always_comb begin
    hcnt_d = (hcnt_q == HLast) ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
    end
    active_d = (hcnt_d < HVisEnd) && (vcnt_d < VVisEnd);
    column_d = active_d ? ColumnAddressWidth'(hcnt_d) : '0;
    line_d   = active_d ? LineAddressWidth'(vcnt_d) : '0;
    // The vertical pulse covers every clock of its lines, including horizontal blanking.
    hsync_d  = !((hcnt_d >= HSyncStart) && (hcnt_d < HSyncEnd));
    vsync_d  = !((vcnt_d >= VSyncStart) && (vcnt_d < VSyncEnd));
  end

  // Counter and output registers. Reset parks the raster at (0,0) with the syncs idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      line_q   <= '0;
      column_q <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      line_q   <= line_d;
      column_q <= column_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign vga.line           = line_q;
  assign vga.column         = column_q;
  assign vga.horizontalSync = hsync_q;
  assign vga.verticalSync   = vsync_q;

`ifdef STATIC_VGA_VISIBLE_EN
  logic visible_q;

  // Active-area flag, registered alongside line/column. Reset value is 1 because (0,0) is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visible_q <= 1'b1;
    end else begin
      visible_q <= active_d;
    end
  end

  assign vga.visible = visible_q;
`endif

endmodule

// File: tb/tb_static_vga_controller.sv
// Testbench for static_vga_controller. The reference model derives the
// expected outputs from the number of clocks since reset release. It uses
// plain modular arithmetic on the frame geometry.
module tb_static_vga_controller;

  localparam int W     = 640;
  localparam int H     = 480;
  localparam int HFP   = 16;
  localparam int HSP   = 96;
  localparam int HBP   = 48;
  localparam int VFP   = 10;
  localparam int VSP   = 2;
  localparam int VBP   = 33;
  localparam int HT    = W + HFP + HSP + HBP;
  localparam int VT    = H + VFP + VSP + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [8:0] ln;
    logic [9:0] col;
    logic       hs;
    logic       vs;
    logic       vis;
  } out_t;

  localparam out_t RST_EXP = '{ln: 9'd0, col: 10'd0, hs: 1'b1, vs: 1'b1, vis: 1'b1};

  logic   clk    = 1'b0;
  logic   rst    = 1'b1;
  logic   clk_en = 1'b1;
  int     n_tests = 0;
  int     n_fail  = 0;
  longint t_now   = 0;

  static_vga_controller_if vga ();

  static_vga_controller dut (
    .clk (clk),
    .rst (rst),
    .vga (vga)
  );

  // Clock with a period of 2. It can be frozen low to observe the asynchronous reset.
  initial forever begin
    #1;
    if (clk_en) clk = ~clk;
  end

  function automatic out_t model(input longint t);
    out_t o;
    int   h;
    int   v;
    bit   act;
    h     = int'(t % HT);
    v     = int'((t / HT) % VT);
    act   = (h < W) && (v < H);
    o.col = act ? 10'(h) : 10'd0;
    o.ln  = act ? 9'(v) : 9'd0;
    o.hs  = !((h >= W + HFP) && (h < W + HFP + HSP));
    o.vs  = !((v >= H + VFP) && (v < H + VFP + VSP));
    o.vis = act;
    return o;
  endfunction

  function automatic out_t observe(input out_t exp);
    out_t o;
    o.ln  = vga.line;
    o.col = vga.column;
    o.hs  = vga.horizontalSync;
    o.vs  = vga.verticalSync;
`ifdef STATIC_VGA_VISIBLE_EN
    o.vis = vga.visible;
`else
    o.vis = exp.vis;
`endif
    return o;
  endfunction

  task automatic test_reset();
    out_t got;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      got = observe(RST_EXP);
      n_tests++;
      if (got !== RST_EXP) begin
        n_fail++;
        $display("FAIL reset_hold got line=%0d col=%0d hs=%b vs=%b vis=%b want line=0 col=0 hs=1 vs=1 vis=1",
                 got.ln, got.col, got.hs, got.vs, got.vis);
      end
    end
    rst   = 1'b0;
    t_now = 0;
  endtask

  task automatic test_raster(input int ncycles);
    out_t   exp;
    out_t   got;
    out_t   prev;
    int     hs_run = 0;
    int     vs_run = 0;
    longint last_hfall = -1;
    int     line_vis = 0;
    int     vis_total = 0;
    int     vis_lines = 0;
    prev = RST_EXP;
    for (int i = 0; i < ncycles; i++) begin
      @(negedge clk);
      t_now++;
      exp = model(t_now);
      got = observe(exp);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL raster t=%0d got line=%0d col=%0d hs=%b vs=%b vis=%b want line=%0d col=%0d hs=%b vs=%b vis=%b",
                 t_now, got.ln, got.col, got.hs, got.vs, got.vis, exp.ln, exp.col, exp.hs, exp.vs, exp.vis);
      end
      if (t_now == 639) begin
        n_tests++;
        if (got.col !== 10'd639 || got.ln !== 9'd0) begin
          n_fail++;
          $display("FAIL spot_639 got line=%0d col=%0d want line=0 col=639", got.ln, got.col);
        end
      end
      if (t_now == 640 || t_now == 1440 || t_now == FRAME) begin
        n_tests++;
        if (got.col !== 10'd0 || got.ln !== 9'd0) begin
          n_fail++;
          $display("FAIL spot_blank t=%0d got line=%0d col=%0d want line=0 col=0", t_now, got.ln, got.col);
        end
      end
      if (t_now == 800) begin
        n_tests++;
        if (got.col !== 10'd0 || got.ln !== 9'd1) begin
          n_fail++;
          $display("FAIL spot_800 got line=%0d col=%0d want line=1 col=0", got.ln, got.col);
        end
      end
      // Horizontal pulse width and line period.
      if (got.hs === 1'b0) hs_run++;
      if (prev.hs === 1'b1 && got.hs === 1'b0) begin
        if (last_hfall >= 0) begin
          n_tests++;
          if (t_now - last_hfall != HT) begin
            n_fail++;
            $display("FAIL hsync_period got %0d want %0d", t_now - last_hfall, HT);
          end
        end
        last_hfall = t_now;
      end
      if (prev.hs === 1'b0 && got.hs === 1'b1) begin
        n_tests++;
        if (hs_run != HSP) begin
          n_fail++;
          $display("FAIL hsync_width got %0d want %0d", hs_run, HSP);
        end
        hs_run = 0;
      end
      // Vertical pulse width in clocks.
      if (got.vs === 1'b0) vs_run++;
      if (prev.vs === 1'b0 && got.vs === 1'b1) begin
        n_tests++;
        if (vs_run != VSP * HT) begin
          n_fail++;
          $display("FAIL vsync_width got %0d want %0d", vs_run, VSP * HT);
        end
        vs_run = 0;
      end
`ifdef STATIC_VGA_VISIBLE_EN
      // Visible clocks per line over one full frame window [HT, FRAME+HT).
      if (t_now >= HT && t_now < FRAME + HT) begin
        if (got.vis === 1'b1) begin
          line_vis++;
          vis_total++;
        end
        if ((t_now % HT) == HT - 1) begin
          if (line_vis != 0) begin
            vis_lines++;
            n_tests++;
            if (line_vis != W) begin
              n_fail++;
              $display("FAIL visible_per_line t=%0d got %0d want %0d", t_now, line_vis, W);
            end
          end
          line_vis = 0;
        end
      end
`endif
      prev = got;
    end
`ifdef STATIC_VGA_VISIBLE_EN
    n_tests++;
    if (vis_lines != H || vis_total != W * H) begin
      n_fail++;
      $display("FAIL visible_per_frame got lines=%0d clocks=%0d want lines=%0d clocks=%0d",
               vis_lines, vis_total, H, W * H);
    end
`endif
  endtask

  task automatic test_midframe_reset();
    out_t   exp;
    out_t   got;
    longint target;
    int     hold;
    // Run on to a random point between lines 20 and 40 of the next frame.
    target = (t_now / FRAME + 1) * FRAME + longint'($urandom_range(20 * HT, 40 * HT));
    while (t_now < target) begin
      @(negedge clk);
      t_now++;
    end
    exp = model(t_now);
    got = observe(exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL midframe_pre t=%0d got line=%0d col=%0d want line=%0d col=%0d",
               t_now, got.ln, got.col, exp.ln, exp.col);
    end
    // Freeze the clock low, then assert reset. Only an asynchronous reset can act here.
    clk_en = 1'b0;
    rst    = 1'b1;
    #3;
    got = observe(RST_EXP);
    n_tests++;
    if (got !== RST_EXP) begin
      n_fail++;
      $display("FAIL async_reset got line=%0d col=%0d hs=%b vs=%b vis=%b want line=0 col=0 hs=1 vs=1 vis=1",
               got.ln, got.col, got.hs, got.vs, got.vis);
    end
    clk_en = 1'b1;
    hold   = int'($urandom_range(1, 5));
    repeat (hold) begin
      @(negedge clk);
      got = observe(RST_EXP);
      n_tests++;
      if (got !== RST_EXP) begin
        n_fail++;
        $display("FAIL reset_clocked got line=%0d col=%0d want line=0 col=0", got.ln, got.col);
      end
    end
    rst   = 1'b0;
    t_now = 0;
    test_raster(2 * HT);
  endtask

  task automatic test_back_to_back();
    out_t exp;
    out_t got;
    int   run;
    for (int k = 0; k < 6; k++) begin
      run = int'($urandom_range(1, 3000));
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        t_now++;
        exp = model(t_now);
        got = observe(exp);
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL b2b_run k=%0d t=%0d got line=%0d col=%0d hs=%b want line=%0d col=%0d hs=%b",
                   k, t_now, got.ln, got.col, got.hs, exp.ln, exp.col, exp.hs);
        end
      end
      rst = 1'b1;
      @(negedge clk);
      got = observe(RST_EXP);
      n_tests++;
      if (got !== RST_EXP) begin
        n_fail++;
        $display("FAIL b2b_reset k=%0d got line=%0d col=%0d hs=%b vs=%b want line=0 col=0 hs=1 vs=1",
                 k, got.ln, got.col, got.hs, got.vs);
      end
      rst   = 1'b0;
      t_now = 0;
    end
  endtask

  initial begin
    test_reset();
    test_raster(FRAME + 2 * HT);
    test_midframe_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
